conv_layer_scheduler: RTL and testbench
=======================================

CONV_LAYER_SCHEDULER -- requirements
Module: conv_layer_scheduler

Interface
REQ-001 SHALL have parameter TIME_STEPS, default 2: SNN time steps per inference.
REQ-002 SHALL have parameter OUTPUT_CHANNELS, default 64: conv output channels.
REQ-003 SHALL have parameter CH_PER_PASS, default 16: output channels the engine computes per pass; OUTPUT_CHANNELS % CH_PER_PASS == 0, else elaboration error.
REQ-004 SHALL derive PASSES = OUTPUT_CHANNELS/CH_PER_PASS, TW = max(1,$clog2(TIME_STEPS)), CW = max(1,$clog2(OUTPUT_CHANNELS)).
REQ-005 SHALL have one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  async active-high reset.
REQ-008 input_avail  input  1  level: spike frame for the current time step is in the input buffer.
REQ-009 input_consumed  output  1  one-cycle pulse: input frame fully used, producer may overwrite.
REQ-010 mem_clear  output  1  one-cycle pulse: zero all membrane potentials.
REQ-011 eng_start  output  1  one-cycle pulse: start one engine pass.
REQ-012 eng_ch_base  output  CW  first output channel of current pass.
REQ-013 eng_ts  output  TW  current time step index.
REQ-014 eng_done  input  1  one-cycle pulse: engine pass finished.
REQ-015 out_ready  input  1  level: downstream can accept an output frame.
REQ-016 layer_avail  output  1  level: output spike frame for eng_ts is complete.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 all_done  output  1  one-cycle pulse: all TIME_STEPS published.

Function
REQ-019 SHALL be a Moore FSM with registered state; all outputs decoded from state and registered counters ts (TW bits) and pass (ceil-log2(PASSES) bits, min 1).
REQ-020 States: IDLE, CLEAR, WAIT_IN, START, RUN, PUBLISH, FINISH.
REQ-021 IDLE: ts=0, pass=0; input_avail=1 -> CLEAR.
REQ-022 CLEAR: mem_clear=1 for exactly one cycle -> START.
REQ-023 WAIT_IN: input_avail=1 -> START; otherwise hold.
REQ-024 START: eng_start=1 for exactly one cycle, eng_ch_base = pass*CH_PER_PASS -> RUN.
REQ-025 RUN: hold until eng_done=1; then if pass<PASSES-1: pass++ -> START; else pass=0 -> PUBLISH.
REQ-026 input_consumed SHALL pulse in the cycle after the eng_done that ends the last pass (first PUBLISH cycle), exactly once per time step.
REQ-027 PUBLISH: layer_avail=1; leave only in a cycle with out_ready=1; then if ts<TIME_STEPS-1: ts++ -> WAIT_IN; else -> FINISH.
REQ-028 FINISH: all_done=1 for one cycle, ts=0 -> IDLE.
REQ-029 eng_ch_base and eng_ts SHALL be stable from START through the end of RUN.
REQ-030 Latency: input_avail sampled high in IDLE at edge k -> mem_clear high after k, eng_start high after k+1.
REQ-031 eng_done outside RUN, including in the same cycle as eng_start, SHALL be ignored.
REQ-032 input_avail deassertion during START/RUN/PUBLISH SHALL be ignored; it is sampled only in IDLE and WAIT_IN.
REQ-033 mem_clear SHALL fire only before time step 0, never between time steps.
REQ-034 TIME_STEPS=1 and PASSES=1 SHALL work: PUBLISH goes directly to FINISH, RUN goes directly to PUBLISH.

Reset
REQ-035 rst=1 SHALL force state IDLE, ts=0, pass=0, and all outputs 0 (eng_ch_base=0, eng_ts=0) asynchronously, including mid-RUN or mid-PUBLISH.
REQ-036 After rst deasserts, an eng_done arriving from an aborted pass SHALL be ignored (the FSM is in IDLE).

Verification
REQ-037 Defaults, input_avail held 1, out_ready=1, eng_done 3 cycles after each eng_start -> 1 mem_clear; 8 eng_start; eng_ch_base 0,16,32,48,0,16,32,48; eng_ts 0,0,0,0,1,1,1,1; 2 input_consumed; 2 layer_avail windows; 1 all_done.
REQ-038 out_ready=0 for 10 cycles during ts 0 PUBLISH -> layer_avail held 10 cycles, eng_ts=0, no eng_start; resumes 1 cycle after out_ready=1.
REQ-039 input_avail=0 after the ts 0 publish, raised 5 cycles later -> FSM waits in WAIT_IN; eng_start for ts 1 one cycle after the rise; no second mem_clear.
REQ-040 Spurious eng_done in IDLE, and in the START cycle -> no state change; pass count still 4 per step.
REQ-041 rst pulse during RUN of pass 2, ts 1 -> all outputs 0 immediately; new input_avail -> mem_clear, then eng_ch_base=0, eng_ts=0.
REQ-042 TIME_STEPS=1, CH_PER_PASS=64 -> sequence mem_clear, eng_start, done, layer_avail, all_done with one pulse each.

Source files
------------

// File: rtl/conv_layer_scheduler.sv
// Sequences one SNN conv layer: clears membranes once, then runs PASSES engine
// passes per time step, publishes each time-step frame, and signals completion.
module conv_layer_scheduler #(
    parameter int TIME_STEPS      = 2,
    parameter int OUTPUT_CHANNELS = 64,
    parameter int CH_PER_PASS     = 16,
    localparam int PASSES = OUTPUT_CHANNELS / CH_PER_PASS,
    localparam int TW     = (TIME_STEPS > 1) ? $clog2(TIME_STEPS) : 1,
    localparam int CW     = (OUTPUT_CHANNELS > 1) ? $clog2(OUTPUT_CHANNELS) : 1,
    localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          input_avail,
    output logic          input_consumed,
    output logic          mem_clear,
    output logic          eng_start,
    output logic [CW-1:0] eng_ch_base,
    output logic [TW-1:0] eng_ts,
    input  logic          eng_done,
    input  logic          out_ready,
    output logic          layer_avail,
    output logic          busy,
    output logic          all_done
);

    generate
        if (OUTPUT_CHANNELS % CH_PER_PASS != 0) begin : g_bad_cfg
            $error("OUTPUT_CHANNELS must be a multiple of CH_PER_PASS");
        end
    endgenerate

    localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);
    localparam logic [TW-1:0] LAST_TS   = TW'(TIME_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_IN,
        S_START,
        S_RUN,
        S_PUBLISH,
        S_FINISH
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] ts_q, ts_d;
    logic [PW-1:0] pass_q, pass_d;
    logic          first_pub_q, first_pub_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ts_q        <= '0;
            pass_q      <= '0;
            first_pub_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            pass_q      <= pass_d;
            first_pub_q <= first_pub_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ts_d        = ts_q;
        pass_d      = pass_q;
        first_pub_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                ts_d   = '0;
                pass_d = '0;
                if (input_avail) state_d = S_CLEAR;
            end
            S_CLEAR:   state_d = S_START;
            S_WAIT_IN: if (input_avail) state_d = S_START;
            S_START:   state_d = S_RUN;
            S_RUN: begin
                // eng_done is only honoured here, so stray pulses elsewhere are dropped
                if (eng_done) begin
                    if (pass_q < LAST_PASS) begin
                        pass_d  = pass_q + 1'b1;
                        state_d = S_START;
                    end else begin
                        pass_d      = '0;
                        first_pub_d = 1'b1;
                        state_d     = S_PUBLISH;
                    end
                end
            end
            S_PUBLISH: begin
                if (out_ready) begin
                    if (ts_q < LAST_TS) begin
                        ts_d    = ts_q + 1'b1;
                        state_d = S_WAIT_IN;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                ts_d    = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // first_pub_q marks the first PUBLISH cycle of each time step
    assign input_consumed = first_pub_q;
    assign mem_clear      = (state_q == S_CLEAR);
    assign eng_start      = (state_q == S_START);
    assign layer_avail    = (state_q == S_PUBLISH);
    assign all_done       = (state_q == S_FINISH);
    assign busy           = (state_q != S_IDLE);
    assign eng_ch_base    = CW'(int'(pass_q) * CH_PER_PASS);
    assign eng_ts         = ts_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Bench for conv_layer_scheduler: directed timing steps plus randomized
// inferences checked against a pass/time-step sequence model.
`timescale 1ns/1ps
module tb_conv_layer_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       input_avail, out_ready, resp_done, spur_done, eng_done;
    logic       input_consumed, mem_clear, eng_start, layer_avail, busy, all_done;
    logic [5:0] eng_ch_base;
    logic [0:0] eng_ts;

    logic       input_avail2, out_ready2, eng_done2;
    logic       input_consumed2, mem_clear2, eng_start2, layer_avail2, busy2, all_done2;
    logic [5:0] eng_ch_base2;
    logic [0:0] eng_ts2;

    assign eng_done = resp_done | spur_done;

    always #5 clk = ~clk;

    conv_layer_scheduler dut (
        .clk(clk), .rst(rst), .input_avail(input_avail), .input_consumed(input_consumed),
        .mem_clear(mem_clear), .eng_start(eng_start), .eng_ch_base(eng_ch_base),
        .eng_ts(eng_ts), .eng_done(eng_done), .out_ready(out_ready),
        .layer_avail(layer_avail), .busy(busy), .all_done(all_done)
    );

    conv_layer_scheduler #(.TIME_STEPS(1), .OUTPUT_CHANNELS(64), .CH_PER_PASS(64)) dut2 (
        .clk(clk), .rst(rst), .input_avail(input_avail2), .input_consumed(input_consumed2),
        .mem_clear(mem_clear2), .eng_start(eng_start2), .eng_ch_base(eng_ch_base2),
        .eng_ts(eng_ts2), .eng_done(eng_done2), .out_ready(out_ready2),
        .layer_avail(layer_avail2), .busy(busy2), .all_done(all_done2)
    );

    int n_chk = 0, n_pass = 0;
    int resp_fixed = 3;
    bit spur_start = 1'b0;

    // monitor state (written only by the monitor process)
    int n_clear = 0, n_start = 0, n_cons = 0, n_win = 0, n_done = 0, stab_err = 0, cons_err = 0;
    int n2_clear = 0, n2_start = 0, n2_cons = 0, n2_win = 0, n2_done = 0;
    int st_ch[$], st_ts[$], win_ts[$];

    // snapshots (written only by the main process)
    int s_clear, s_start, s_cons, s_win, s_done, s_stab, s_cerr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] outs1();
        return {19'd0, busy, mem_clear, eng_start, layer_avail, all_done, input_consumed, eng_ch_base, eng_ts};
    endfunction

    function automatic logic [31:0] outs2();
        return {19'd0, busy2, mem_clear2, eng_start2, layer_avail2, all_done2, input_consumed2, eng_ch_base2, eng_ts2};
    endfunction

    // engine model: eng_done a fixed or random number of cycles after each start
    initial begin
        int cnt;
        cnt = 0;
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            resp_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) resp_done = 1'b1;
            end
            if (eng_start) begin
                cnt = (resp_fixed > 0) ? resp_fixed : int'($urandom_range(1, 5));
                if (spur_start) resp_done = 1'b1;
            end
        end
    end

    initial begin
        bit la_prev, in_pass, la_prev2;
        int pch, pts;
        la_prev = 0; in_pass = 0; la_prev2 = 0; pch = 0; pts = 0;
        forever begin
            @(negedge clk);
            if (mem_clear) n_clear++;
            if (input_consumed) n_cons++;
            if (all_done) n_done++;
            if (layer_avail && !la_prev) begin
                n_win++;
                win_ts.push_back(int'(eng_ts));
            end
            if (input_consumed != (layer_avail && !la_prev)) cons_err++;
            la_prev = layer_avail;
            if (eng_start) begin
                n_start++;
                st_ch.push_back(int'(eng_ch_base));
                st_ts.push_back(int'(eng_ts));
                pch = int'(eng_ch_base);
                pts = int'(eng_ts);
                in_pass = 1;
            end else if (!busy || layer_avail) begin
                in_pass = 0;
            end else if (in_pass && (int'(eng_ch_base) != pch || int'(eng_ts) != pts)) begin
                stab_err++;
            end
            if (mem_clear2) n2_clear++;
            if (eng_start2) n2_start++;
            if (input_consumed2) n2_cons++;
            if (layer_avail2 && !la_prev2) n2_win++;
            if (all_done2) n2_done++;
            la_prev2 = layer_avail2;
        end
    end

    task automatic snap();
        s_clear = n_clear; s_start = n_start; s_cons = n_cons; s_win = n_win;
        s_done = n_done; s_stab = stab_err; s_cerr = cons_err;
    endtask

    // reference: one clear, then for each step every pass in channel order, one frame per step
    task automatic check_infer(input string tag);
        int k;
        chk({tag, "_n_start"}, n_start - s_start, 8);
        k = s_start;
        for (int t = 0; t < 2; t++)
            for (int p = 0; p < 4; p++) begin
                if (k < st_ch.size()) begin
                    chk({tag, "_ch_base"}, st_ch[k], p * 16);
                    chk({tag, "_ts"}, st_ts[k], t);
                end
                k++;
            end
        chk({tag, "_n_clear"}, n_clear - s_clear, 1);
        chk({tag, "_n_consumed"}, n_cons - s_cons, 2);
        chk({tag, "_n_windows"}, n_win - s_win, 2);
        for (int t = 0; t < 2; t++)
            if (s_win + t < win_ts.size()) chk({tag, "_win_ts"}, win_ts[s_win + t], t);
        chk({tag, "_n_all_done"}, n_done - s_done, 1);
        chk({tag, "_stability"}, stab_err - s_stab, 0);
        chk({tag, "_consumed_align"}, cons_err - s_cerr, 0);
    endtask

    task automatic wait_done(input bit rnd, output bit ok);
        ok = 0; input_avail = 1; out_ready = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (all_done) begin ok = 1; break; end
            if (rnd) begin
                input_avail = ($urandom_range(0, 2) != 0);
                out_ready   = ($urandom_range(0, 2) != 0);
            end
        end
        input_avail = 0; out_ready = 1;
    endtask

    task automatic wait_la(output bit ok);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            if (layer_avail) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    initial begin
        bit ok;
        int bad;
        rst = 1; input_avail = 0; out_ready = 1; spur_done = 0;
        input_avail2 = 0; out_ready2 = 1; eng_done2 = 0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs1(), 0);
        chk("reset_outs2", outs2(), 0);
        rst = 0;
        @(negedge clk);

        // spurious eng_done while idle
        spur_done = 1;
        @(negedge clk);
        spur_done = 0;
        chk("idle_spur_busy", busy, 0);
        @(negedge clk);
        chk("idle_spur_busy2", busy, 0);

        // nominal run with start latency
        snap();
        input_avail = 1;
        @(negedge clk);
        chk("lat_mem_clear", {mem_clear, eng_start}, 2'b10);
        @(negedge clk);
        chk("lat_eng_start", {mem_clear, eng_start}, 2'b01);
        wait_done(0, ok);
        chk("nominal_timeout", ok, 1);
        @(negedge clk);
        check_infer("nominal");

        // downstream stall for 10 cycles in ts 0 publish; spurious done in START
        spur_start = 1;
        snap();
        out_ready = 0; input_avail = 1;
        @(negedge clk);
        wait_la(ok);
        chk("stall_la_timeout", ok, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(layer_avail && eng_ts == 0 && !eng_start)) bad++;
            if (i == 9) out_ready = 1;
            @(negedge clk);
        end
        chk("stall_hold", bad, 0);
        chk("stall_release", {layer_avail, eng_start, eng_ts}, 3'b001);
        @(negedge clk);
        chk("stall_resume", {eng_start, eng_ts}, 2'b11);
        wait_done(0, ok);
        chk("stall_timeout", ok, 1);
        @(negedge clk);
        check_infer("stall");
        spur_start = 0;

        // input frame late for ts 1
        snap();
        input_avail = 1; out_ready = 1;
        @(negedge clk);
        wait_la(ok);
        chk("gap_la_timeout", ok, 1);
        input_avail = 0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (eng_start || !busy || layer_avail) bad++;
            if (i == 4) input_avail = 1;
        end
        chk("gap_wait", bad, 0);
        @(negedge clk);
        chk("gap_resume", {eng_start, eng_ts, mem_clear}, 3'b110);
        wait_done(0, ok);
        chk("gap_timeout", ok, 1);
        @(negedge clk);
        check_infer("gap");

        // randomized handshakes and engine latency
        for (int r = 0; r < 6; r++) begin
            resp_fixed = 0;
            spur_start = bit'($urandom_range(0, 1));
            snap();
            wait_done(1, ok);
            chk("rand_timeout", ok, 1);
            @(negedge clk);
            check_infer("rand");
        end
        resp_fixed = 3; spur_start = 0;

        // reset during RUN of pass 2, ts 1
        input_avail = 1;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (eng_start && eng_ch_base == 32 && eng_ts == 1) begin ok = 1; break; end
        end
        chk("rst_find_timeout", ok, 1);
        input_avail = 0;
        @(negedge clk);
        #2 rst = 1;
        #1 chk("rst_async_outs", outs1(), 0);
        @(negedge clk);
        rst = 0;
        snap();
        @(negedge clk);
        @(negedge clk);
        chk("rst_stale_done", busy, 0);
        @(negedge clk);
        chk("rst_stale_done2", busy, 0);
        input_avail = 1;
        @(negedge clk);
        chk("rst_restart_clear", {mem_clear, busy}, 2'b11);
        @(negedge clk);
        chk("rst_restart_start", {eng_start, eng_ch_base, eng_ts}, {1'b1, 6'd0, 1'b0});
        wait_done(0, ok);
        chk("rst_timeout", ok, 1);
        @(negedge clk);
        check_infer("after_rst");

        // single time step, single pass instance
        input_avail2 = 1;
        @(negedge clk);
        chk("one_clear", {mem_clear2, eng_start2}, 2'b10);
        @(negedge clk);
        chk("one_start", {eng_start2, eng_ch_base2, eng_ts2}, {1'b1, 6'd0, 1'b0});
        input_avail2 = 0;
        eng_done2 = 1;
        @(negedge clk);
        eng_done2 = 0;
        chk("one_start_done_ignored", {busy2, layer_avail2, eng_start2}, 3'b100);
        @(negedge clk);
        eng_done2 = 1;
        @(negedge clk);
        eng_done2 = 0;
        chk("one_publish", {layer_avail2, input_consumed2}, 2'b11);
        @(negedge clk);
        chk("one_all_done", {all_done2, layer_avail2}, 2'b10);
        @(negedge clk);
        chk("one_idle", busy2, 0);
        @(negedge clk);
        chk("one_pulses", {n2_clear[3:0], n2_start[3:0], n2_cons[3:0], n2_win[3:0], n2_done[3:0]}, 20'h11111);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
